// File: rtl/sram_controller.sv
// sram_controller: bridges 32-bit Memory-stage loads/stores to a 16-bit asynchronous SRAM.
// Each access is split into a low half-word then a high half-word phase, each held on the
// bus for HALF_CYCLES cycles, followed by a one-cycle DONE state. ready drops while an
// access is pending and is used by the pipeline as its freeze.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rd_en      load request (sampled in IDLE only)
//   wr_en      store request (wins over rd_en)
//   address    word-aligned byte address
//   write_data store data
//   read_data  registered load result, updated when a read's high half completes
//   ready      high when idle with no request, or in DONE
//   SRAM_DQ    16-bit SRAM data bus, driven only during write phases
//   SRAM_ADDR  SRAM half-word address
//   SRAM_WE_N  SRAM write enable, active-low
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned HALF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {StIdle, StAccLo, StAccHi, StDone} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        is_wr_q;
  logic [15:0] wdata_hi_q;
  logic [15:0] lo_buf_q;
  logic [31:0] read_data_q;
  logic [17:0] sram_addr_q;
  logic        we_n_q;
  logic        dq_oe_q;
  logic [15:0] dq_out_q;

  logic [16:0] word_idx;
  logic        last_cycle;

  // Offset bits above 18 are dropped, so the SRAM window wraps every 2^19 bytes.
  assign word_idx   = 17'((address - BASE_ADDR) >> 2);
  assign last_cycle = (cnt_q == 4'(HALF_CYCLES - 1));

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign read_data = read_data_q;
  assign ready     = ((state_q == StIdle) && !(rd_en || wr_en)) || (state_q == StDone);

  // Bus outputs are registered and set on the edge that enters each phase, so they are
  // valid for the whole phase and are released asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      wdata_hi_q  <= '0;
      lo_buf_q    <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_en || wr_en) begin
            state_q     <= StAccLo;
            cnt_q       <= '0;
            is_wr_q     <= wr_en;
            wdata_hi_q  <= write_data[31:16];
            sram_addr_q <= {word_idx, 1'b0};
            we_n_q      <= ~wr_en;
            dq_oe_q     <= wr_en;
            dq_out_q    <= write_data[15:0];
          end
        end
        StAccLo: begin
          if (last_cycle) begin
            state_q        <= StAccHi;
            cnt_q          <= '0;
            sram_addr_q[0] <= 1'b1;
            dq_out_q       <= wdata_hi_q;
            if (!is_wr_q) lo_buf_q <= SRAM_DQ;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StAccHi: begin
          if (last_cycle) begin
            state_q     <= StDone;
            cnt_q       <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            if (!is_wr_q) read_data_q <= {SRAM_DQ, lo_buf_q};
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a default instance (HALF_CYCLES = 2) with a read/write SRAM
// model, and a HALF_CYCLES = 1 instance with a preloaded read-only SRAM model.
module tb_sram_controller;

  localparam int H1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance 1
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data1;
  logic        ready1, we1;
  logic [17:0] addr1;
  wire  [15:0] dq1;
  logic        drv1 = 1'b0, probe1 = 1'b0;
  logic [15:0] mem1 [0:262143];

  assign dq1 = drv1 ? (probe1 ? 16'h0000 : mem1[addr1]) : 16'hzzzz;

  sram_controller #(.BASE_ADDR(32'd1024), .HALF_CYCLES(H1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data1),
    .ready     (ready1),
    .SRAM_DQ   (dq1),
    .SRAM_ADDR (addr1),
    .SRAM_WE_N (we1)
  );

  always @(posedge clk) if (!we1) mem1[addr1] <= dq1;

  // Write log: one entry {addr, data} per distinct half-word write phase.
  logic [33:0] wr_obs [$];
  logic [33:0] wr_exp [$];
  logic        we1_prev = 1'b1;
  logic [17:0] addr1_prev = '0;
  always @(negedge clk) begin
    if (!we1 && (we1_prev || addr1 != addr1_prev)) wr_obs.push_back({addr1, dq1});
    we1_prev   <= we1;
    addr1_prev <= addr1;
  end

  logic [31:0] rd_exp [$];

  // Instance 2 (reads only)
  logic        rd_en2 = 1'b0;
  logic [31:0] address2 = '0;
  logic [31:0] read_data2;
  logic        ready2, we2;
  logic [17:0] addr2;
  wire  [15:0] dq2;
  logic [15:0] mem2 [0:262143];
  logic [31:0] rd2_exp [$];

  assign dq2 = we2 ? mem2[addr2] : 16'hzzzz;

  sram_controller #(.BASE_ADDR(32'd1024), .HALF_CYCLES(1)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en2),
    .wr_en     (1'b0),
    .address   (address2),
    .write_data(32'h0),
    .read_data (read_data2),
    .ready     (ready2),
    .SRAM_DQ   (dq2),
    .SRAM_ADDR (addr2),
    .SRAM_WE_N (we2)
  );

  // Drives one request on instance 1 and follows it to DONE, reporting what it saw.
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, output int low_cycles,
                        output logic [17:0] a_lo, output logic [17:0] a_hi,
                        output logic we_lo, output logic [31:0] rd_obs);
    logic done;
    done = 1'b0; a_lo = '0; a_hi = '0; we_lo = 1'b1; rd_obs = '0;
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    #1;
    low_cycles = ready1 ? 0 : 1;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        wr_en = 1'b0; rd_en = 1'b0;
        a_lo = addr1; we_lo = we1;
      end
      if (c == H1 + 1) a_hi = addr1;
      if (ready1) begin
        done = 1'b1; rd_obs = read_data1;
      end else begin
        low_cycles++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_cmp++; if (read_data1 !== 32'h0) begin n_bad++; $display("FAIL reset_read_data: got %h want 0", read_data1); end
    n_cmp++; if (ready1 !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready1); end
    n_cmp++; if (we1 !== 1'b1) begin n_bad++; $display("FAIL reset_we_n: got %b want 1", we1); end
    n_cmp++; if (addr1 !== 18'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", addr1); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_write_read();
    int lc; logic [17:0] alo, ahi; logic wel; logic [31:0] ro, ev; logic [33:0] e, o;
    drv1 = 1'b0;
    wr_exp.push_back({18'd0, 16'hBEEF}); wr_exp.push_back({18'd1, 16'hDEAD});
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lc, alo, ahi, wel, ro);
    n_cmp++; if (lc != 5) begin n_bad++; $display("FAIL wr_ready_low: got %0d want 5", lc); end
    while (wr_exp.size() > 0) begin
      e = wr_exp.pop_front(); n_cmp++;
      if (wr_obs.size() == 0) begin n_bad++; $display("FAIL wr_log: got none want %h", e); end
      else begin o = wr_obs.pop_front(); if (o !== e) begin n_bad++; $display("FAIL wr_log: got %h want %h", o, e); end end
    end
    n_cmp++; if (mem1[0] !== 16'hBEEF) begin n_bad++; $display("FAIL mem_hw0: got %h want beef", mem1[0]); end
    n_cmp++; if (mem1[1] !== 16'hDEAD) begin n_bad++; $display("FAIL mem_hw1: got %h want dead", mem1[1]); end
    drv1 = 1'b1;
    rd_exp.push_back(32'hDEADBEEF);
    access(1'b0, 1'b1, 32'd1024, 32'h0, lc, alo, ahi, wel, ro);
    ev = rd_exp.pop_front();
    n_cmp++; if (ro !== ev) begin n_bad++; $display("FAIL rd_data: got %h want %h", ro, ev); end
    n_cmp++; if (lc != 5) begin n_bad++; $display("FAIL rd_ready_low: got %0d want 5", lc); end
    drv1 = 1'b0;
  endtask

  task automatic test_mapping();
    int lc; logic [17:0] alo, ahi; logic wel; logic [31:0] ro; logic [33:0] e, o;
    wr_exp.push_back({18'd4, 16'h5678}); wr_exp.push_back({18'd5, 16'h1234});
    access(1'b1, 1'b0, 32'd1032, 32'h12345678, lc, alo, ahi, wel, ro);
    n_cmp++; if (alo !== 18'd4) begin n_bad++; $display("FAIL map_lo_addr: got %0d want 4", alo); end
    n_cmp++; if (ahi !== 18'd5) begin n_bad++; $display("FAIL map_hi_addr: got %0d want 5", ahi); end
    while (wr_exp.size() > 0) begin
      e = wr_exp.pop_front(); n_cmp++;
      if (wr_obs.size() == 0) begin n_bad++; $display("FAIL map_log: got none want %h", e); end
      else begin o = wr_obs.pop_front(); if (o !== e) begin n_bad++; $display("FAIL map_log: got %h want %h", o, e); end end
    end
  endtask

  task automatic test_wrap();
    int lc; logic [17:0] alo, ahi; logic wel; logic [31:0] ro, ev; logic [33:0] e, o;
    wr_exp.push_back({18'd0, 16'h0F0F}); wr_exp.push_back({18'd1, 16'hA5A5});
    access(1'b1, 1'b0, 32'd1024, 32'hA5A50F0F, lc, alo, ahi, wel, ro);
    while (wr_exp.size() > 0) begin
      e = wr_exp.pop_front(); n_cmp++;
      if (wr_obs.size() == 0) begin n_bad++; $display("FAIL wrap_log: got none want %h", e); end
      else begin o = wr_obs.pop_front(); if (o !== e) begin n_bad++; $display("FAIL wrap_log: got %h want %h", o, e); end end
    end
    drv1 = 1'b1;
    rd_exp.push_back(32'hA5A50F0F);
    access(1'b0, 1'b1, 32'd1024 + 32'h80000, 32'h0, lc, alo, ahi, wel, ro);
    ev = rd_exp.pop_front();
    n_cmp++; if (alo !== 18'd0) begin n_bad++; $display("FAIL wrap_lo_addr: got %0d want 0", alo); end
    n_cmp++; if (ahi !== 18'd1) begin n_bad++; $display("FAIL wrap_hi_addr: got %0d want 1", ahi); end
    n_cmp++; if (ro !== ev) begin n_bad++; $display("FAIL wrap_data: got %h want %h", ro, ev); end
    drv1 = 1'b0;
  endtask

  task automatic test_rd_wr_both();
    int lc; logic [17:0] alo, ahi; logic wel; logic [31:0] ro; logic [33:0] e, o;
    wr_exp.push_back({18'd2, 16'h0001}); wr_exp.push_back({18'd3, 16'h0000});
    access(1'b1, 1'b1, 32'd1028, 32'h00000001, lc, alo, ahi, wel, ro);
    n_cmp++; if (wel !== 1'b0) begin n_bad++; $display("FAIL both_we_n: got %b want 0", wel); end
    n_cmp++; if (read_data1 !== 32'hA5A50F0F) begin n_bad++; $display("FAIL both_read_data: got %h want a5a50f0f", read_data1); end
    while (wr_exp.size() > 0) begin
      e = wr_exp.pop_front(); n_cmp++;
      if (wr_obs.size() == 0) begin n_bad++; $display("FAIL both_log: got none want %h", e); end
      else begin o = wr_obs.pop_front(); if (o !== e) begin n_bad++; $display("FAIL both_log: got %h want %h", o, e); end end
    end
  endtask

  task automatic test_reset_mid_write();
    int lc; logic [17:0] alo, ahi; logic wel; logic [31:0] ro, ev; logic [33:0] e, o;
    wr_exp.push_back({18'd8, 16'hF00D}); wr_exp.push_back({18'd9, 16'hCAFE});
    drv1 = 1'b0;
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Second high-half cycle: pull the bus low from the bench so a still-driving DUT shows up.
    rst = 1'b0; drv1 = 1'b1; probe1 = 1'b1;
    #1;
    n_cmp++; if (we1 !== 1'b1) begin n_bad++; $display("FAIL rstmid_we_n: got %b want 1", we1); end
    n_cmp++; if (dq1 !== 16'h0000) begin n_bad++; $display("FAIL rstmid_dq_released: got %h want 0000", dq1); end
    n_cmp++; if (ready1 !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", ready1); end
    n_cmp++; if (read_data1 !== 32'h0) begin n_bad++; $display("FAIL rstmid_read_data: got %h want 0", read_data1); end
    drv1 = 1'b0; probe1 = 1'b0;
    while (wr_exp.size() > 0) begin
      e = wr_exp.pop_front(); n_cmp++;
      if (wr_obs.size() == 0) begin n_bad++; $display("FAIL rstmid_log: got none want %h", e); end
      else begin o = wr_obs.pop_front(); if (o !== e) begin n_bad++; $display("FAIL rstmid_log: got %h want %h", o, e); end end
    end
    @(negedge clk); rst = 1'b1;
    drv1 = 1'b1;
    rd_exp.push_back(32'hA5A50F0F);
    access(1'b0, 1'b1, 32'd1024, 32'h0, lc, alo, ahi, wel, ro);
    ev = rd_exp.pop_front();
    n_cmp++; if (ro !== ev) begin n_bad++; $display("FAIL rstmid_recover: got %h want %h", ro, ev); end
    drv1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int first, second, pulses; logic [31:0] ev;
    first = -1; second = -1; pulses = 0;
    rd2_exp.push_back(32'h11112222); rd2_exp.push_back(32'h33334444);
    @(negedge clk);
    rd_en2 = 1'b1; address2 = 32'd1024;
    for (int c = 1; c <= 20 && pulses < 2; c++) begin
      @(posedge clk); #1;
      if (c == first + 1) begin
        n_cmp++; if (ready2 !== 1'b0) begin n_bad++; $display("FAIL b2b_pulse_width: got %b want 0", ready2); end
      end
      if (ready2) begin
        pulses++;
        if (pulses == 1) first = c; else second = c;
        ev = rd2_exp.pop_front();
        n_cmp++; if (read_data2 !== ev) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", pulses, read_data2, ev); end
        address2 = 32'd1028;
      end
    end
    rd_en2 = 1'b0;
    n_cmp++; if (first != 3) begin n_bad++; $display("FAIL b2b_first_done: got %0d want 3", first); end
    n_cmp++; if (second - first != 4) begin n_bad++; $display("FAIL b2b_period: got %0d want 4", second - first); end
    n_cmp++; if (rd2_exp.size() != 0) begin n_bad++; $display("FAIL b2b_pending: got %0d want 0", rd2_exp.size()); end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    mem2[0] = 16'h2222; mem2[1] = 16'h1111;
    mem2[2] = 16'h4444; mem2[3] = 16'h3333;
    test_reset();
    test_write_read();
    test_mapping();
    test_wrap();
    test_rd_wr_both();
    test_reset_mid_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
